// File: rtl/alu_share_arb.sv
// Two-port arbiter in front of one shared combinational ALU: the winning op is
// registered into an issue stage that drives the ALU, and the result is registered into a tagged response stage.
module alu_share_arb #(
  parameter int unsigned MODE       = 0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,

  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [5:0]  req0_fun_i,
  input  logic        req0_sign_i,

  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic [5:0]  req1_fun_i,
  input  logic        req1_sign_i,

  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [5:0]  alu_fun_o,
  output logic        alu_sign_o,
  input  logic [31:0] alu_z_i,

  output logic        rsp0_valid_o,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp_z_o,
  output logic        busy_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic        pick1;
  logic        ready0;
  logic        ready1;
  logic        accept;

  logic        last_grant_q, last_grant_d;
  logic [3:0]  starve_q, starve_d;

  logic        iss_valid_q, iss_valid_d;
  logic        iss_port_q, iss_port_d;
  logic [31:0] iss_a_q, iss_a_d;
  logic [31:0] iss_b_q, iss_b_d;
  logic [5:0]  iss_fun_q, iss_fun_d;
  logic        iss_sign_q, iss_sign_d;

  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_z_q, rsp_z_d;

  // pick1 only matters on a tie: it says port 1 should win when both request.
  generate
    if (MODE == 0) begin : g_round_robin
      assign pick1 = ~last_grant_q;
    end else begin : g_fixed_prio
      assign pick1 = (starve_q == STARVE_LIM);
    end
  endgenerate

  assign ready0 = req0_valid_i & ~flush_i & ~(req1_valid_i & pick1);
  assign ready1 = req1_valid_i & ~flush_i & (~req0_valid_i | pick1);
  assign accept = ready0 | ready1;

  always_comb begin
    iss_valid_d  = accept;
    iss_port_d   = iss_port_q;
    iss_a_d      = iss_a_q;
    iss_b_d      = iss_b_q;
    iss_fun_d    = iss_fun_q;
    iss_sign_d   = iss_sign_q;
    last_grant_d = last_grant_q;
    if (ready1) begin
      iss_port_d   = 1'b1;
      iss_a_d      = req1_a_i;
      iss_b_d      = req1_b_i;
      iss_fun_d    = req1_fun_i;
      iss_sign_d   = req1_sign_i;
      last_grant_d = 1'b1;
    end else if (ready0) begin
      iss_port_d   = 1'b0;
      iss_a_d      = req0_a_i;
      iss_b_d      = req0_b_i;
      iss_fun_d    = req0_fun_i;
      iss_sign_d   = req0_sign_i;
      last_grant_d = 1'b0;
    end
  end

  // The counter runs in both modes but only steers the grant in fixed-priority mode.
  always_comb begin
    starve_d = starve_q;
    if (!req1_valid_i || ready1) begin
      starve_d = 4'd0;
    end else if (!flush_i && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp_valid
      assign rsp_valid_d[gi] = iss_valid_q & (iss_port_q == 1'(gi)) & ~flush_i;
    end
  endgenerate

  assign rsp_z_d = iss_valid_q ? alu_z_i : rsp_z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      starve_q     <= 4'd0;
      iss_valid_q  <= 1'b0;
      iss_port_q   <= 1'b0;
      iss_a_q      <= 32'd0;
      iss_b_q      <= 32'd0;
      iss_fun_q    <= 6'd0;
      iss_sign_q   <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_z_q      <= 32'd0;
    end else begin
      last_grant_q <= last_grant_d;
      starve_q     <= starve_d;
      iss_valid_q  <= iss_valid_d;
      iss_port_q   <= iss_port_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_fun_q    <= iss_fun_d;
      iss_sign_q   <= iss_sign_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_z_q      <= rsp_z_d;
    end
  end

  assign req0_ready_o = ready0;
  assign req1_ready_o = ready1;
  assign alu_a_o      = iss_a_q;
  assign alu_b_o      = iss_b_q;
  assign alu_fun_o    = iss_fun_q;
  assign alu_sign_o   = iss_sign_q;
  assign rsp0_valid_o = rsp_valid_q[0];
  assign rsp1_valid_o = rsp_valid_q[1];
  assign rsp_z_o      = rsp_z_q;
  assign busy_o       = iss_valid_q | rsp_valid_q[0] | rsp_valid_q[1];

`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(ready0 && ready1));
  a_no_grant_on_flush: assert property (@(posedge clk) disable iff (!rst_n) flush_i |-> !accept);
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench: instance u_rr runs round-robin, u_fp runs fixed priority with
// STARVE_MAX=4; each is fed by a small behavioural ALU.
module tb_alu_share_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] F_ADD = 6'b000000;
  localparam logic [5:0] F_SUB = 6'b000001;
  localparam logic [5:0] F_AND = 6'b011000;
  localparam logic [5:0] F_SLT = 6'b110101;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] f, input logic s);
    case (f)
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_AND:   return a & b;
      F_SLT:   return s ? {31'd0, ($signed(a) < $signed(b))} : {31'd0, (a < b)};
      default: return 32'd0;
    endcase
  endfunction

  // Round-robin instance signals
  logic        a_flush = 1'b0;
  logic        a_v0 = 1'b0, a_v1 = 1'b0, a_rdy0, a_rdy1;
  logic [31:0] a_opa0 = '0, a_opb0 = '0, a_opa1 = '0, a_opb1 = '0;
  logic [5:0]  a_fun0 = '0, a_fun1 = '0;
  logic        a_sgn0 = 1'b0, a_sgn1 = 1'b0;
  logic [31:0] a_alu_a, a_alu_b, a_alu_z, a_rsp_z;
  logic [5:0]  a_alu_fun;
  logic        a_alu_sign, a_rsp0, a_rsp1, a_busy;

  // Fixed-priority instance signals
  logic        b_v0 = 1'b0, b_v1 = 1'b0, b_rdy0, b_rdy1;
  logic [31:0] b_opa0 = '0, b_opb0 = '0, b_opa1 = '0, b_opb1 = '0;
  logic [5:0]  b_fun0 = '0, b_fun1 = '0;
  logic        b_sgn0 = 1'b0, b_sgn1 = 1'b0;
  logic [31:0] b_alu_a, b_alu_b, b_alu_z, b_rsp_z;
  logic [5:0]  b_alu_fun;
  logic        b_alu_sign, b_rsp0, b_rsp1, b_busy;

  assign a_alu_z = alu_fn(a_alu_a, a_alu_b, a_alu_fun, a_alu_sign);
  assign b_alu_z = alu_fn(b_alu_a, b_alu_b, b_alu_fun, b_alu_sign);

  alu_share_arb #(.MODE(0), .STARVE_MAX(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .flush_i(a_flush),
    .req0_valid_i(a_v0), .req0_ready_o(a_rdy0), .req0_a_i(a_opa0), .req0_b_i(a_opb0),
    .req0_fun_i(a_fun0), .req0_sign_i(a_sgn0),
    .req1_valid_i(a_v1), .req1_ready_o(a_rdy1), .req1_a_i(a_opa1), .req1_b_i(a_opb1),
    .req1_fun_i(a_fun1), .req1_sign_i(a_sgn1),
    .alu_a_o(a_alu_a), .alu_b_o(a_alu_b), .alu_fun_o(a_alu_fun), .alu_sign_o(a_alu_sign),
    .alu_z_i(a_alu_z),
    .rsp0_valid_o(a_rsp0), .rsp1_valid_o(a_rsp1), .rsp_z_o(a_rsp_z), .busy_o(a_busy)
  );

  alu_share_arb #(.MODE(1), .STARVE_MAX(4)) u_fp (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
    .req0_valid_i(b_v0), .req0_ready_o(b_rdy0), .req0_a_i(b_opa0), .req0_b_i(b_opb0),
    .req0_fun_i(b_fun0), .req0_sign_i(b_sgn0),
    .req1_valid_i(b_v1), .req1_ready_o(b_rdy1), .req1_a_i(b_opa1), .req1_b_i(b_opb1),
    .req1_fun_i(b_fun1), .req1_sign_i(b_sgn1),
    .alu_a_o(b_alu_a), .alu_b_o(b_alu_b), .alu_fun_o(b_alu_fun), .alu_sign_o(b_alu_sign),
    .alu_z_i(b_alu_z),
    .rsp0_valid_o(b_rsp0), .rsp1_valid_o(b_rsp1), .rsp_z_o(b_rsp_z), .busy_o(b_busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_v0 = 1'b0; a_v1 = 1'b0; a_flush = 1'b0;
    b_v0 = 1'b0; b_v1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({a_rsp0, a_rsp1, a_busy, a_rdy0, a_rdy1} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b expected 00000", {a_rsp0, a_rsp1, a_busy, a_rdy0, a_rdy1});
    end
    checks++; if ({a_alu_a, a_alu_b, a_alu_fun, a_alu_sign} !== 71'd0) begin
      errors++; $display("FAIL reset_alu got %h expected 0", {a_alu_a, a_alu_b, a_alu_fun, a_alu_sign});
    end
    checks++; if (a_rsp_z !== 32'd0) begin
      errors++; $display("FAIL reset_rsp_z got %h expected 0", a_rsp_z);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: outputs checked during reset");
  endtask

  task automatic test_single_req0();
    a_v0 = 1'b1; a_fun0 = F_ADD; a_sgn0 = 1'b0; a_opa0 = 32'd5; a_opb0 = 32'd7;
    #1;
    checks++; if ({a_rdy0, a_rdy1} !== 2'b10) begin
      errors++; $display("FAIL single_ready got %b expected 10", {a_rdy0, a_rdy1});
    end
    @(posedge clk); #1;
    a_v0 = 1'b0;
    checks++; if ({a_alu_a, a_busy, a_rsp0} !== {32'd5, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single_issue got alu_a=%0d busy=%b rsp0=%b expected 5 1 0", a_alu_a, a_busy, a_rsp0);
    end
    @(posedge clk); #1;
    checks++; if ({a_rsp0, a_rsp1, a_rsp_z} !== {2'b10, 32'd12}) begin
      errors++; $display("FAIL single_rsp got rsp0=%b rsp1=%b z=%0d expected 1 0 12", a_rsp0, a_rsp1, a_rsp_z);
    end
    @(posedge clk); #1;
    checks++; if ({a_rsp0, a_rsp1, a_busy, a_rsp_z} !== {3'b000, 32'd12}) begin
      errors++; $display("FAIL single_drain got rsp0=%b rsp1=%b busy=%b z=%0d expected 0 0 0 12", a_rsp0, a_rsp1, a_busy, a_rsp_z);
    end
    $display("single_req0: ADD 5+7 -> %0d", a_rsp_z);
  endtask

  task automatic test_round_robin();
    logic g;
    logic [31:0] ez;
    do_reset();
    a_v0 = 1'b1; a_fun0 = F_SUB; a_sgn0 = 1'b0; a_opa0 = 32'd9;    a_opb0 = 32'd4;
    a_v1 = 1'b1; a_fun1 = F_AND; a_sgn1 = 1'b0; a_opa1 = 32'hF0;   a_opb1 = 32'h3C;
    for (int e = 0; e < 6; e++) begin
      if (e == 4) begin a_v0 = 1'b0; a_v1 = 1'b0; end
      #1;
      if (e < 4) begin
        g = (e % 2 == 1);
        checks++; if ({a_rdy0, a_rdy1} !== {~g, g}) begin
          errors++; $display("FAIL rr_grant[%0d] got %b expected %b", e, {a_rdy0, a_rdy1}, {~g, g});
        end
      end
      @(posedge clk); #1;
      if (e >= 1 && e <= 4) begin
        g = ((e - 1) % 2 == 1);
        ez = g ? 32'h30 : 32'd5;
        checks++; if ({a_rsp0, a_rsp1, a_rsp_z} !== {~g, g, ez}) begin
          errors++; $display("FAIL rr_rsp[%0d] got rsp0=%b rsp1=%b z=%h expected %b %b %h", e - 1, a_rsp0, a_rsp1, a_rsp_z, ~g, g, ez);
        end
        $display("round_robin: op %0d port %0d z=%h", e - 1, g, a_rsp_z);
      end else if (e == 5) begin
        checks++; if ({a_rsp0, a_rsp1} !== 2'b00) begin
          errors++; $display("FAIL rr_idle got %b expected 00", {a_rsp0, a_rsp1});
        end
      end
    end
  endtask

  task automatic test_starvation();
    logic g, pg;
    logic v1_tab [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic r1_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    b_v0 = 1'b1; b_fun0 = F_ADD; b_opa0 = 32'd1;  b_opb0 = 32'd2;
    b_v1 = 1'b1; b_fun1 = F_SUB; b_opa1 = 32'd10; b_opb1 = 32'd3;
    pg = 1'b0;
    for (int e = 0; e < 10; e++) begin
      #1;
      g = (e % 5 == 4);
      checks++; if ({b_rdy0, b_rdy1} !== {~g, g}) begin
        errors++; $display("FAIL starve_grant[%0d] got %b expected %b", e, {b_rdy0, b_rdy1}, {~g, g});
      end
      @(posedge clk); #1;
      if (e >= 1) begin
        checks++; if ({b_rsp0, b_rsp1, b_rsp_z} !== {~pg, pg, (pg ? 32'd7 : 32'd3)}) begin
          errors++; $display("FAIL starve_rsp[%0d] got rsp0=%b rsp1=%b z=%0d expected port %0d", e - 1, b_rsp0, b_rsp1, b_rsp_z, pg);
        end
      end
      $display("starvation: cycle %0d grant port %0d", e, g);
      pg = g;
    end
    for (int c = 0; c < 8; c++) begin
      b_v1 = v1_tab[c];
      #1;
      checks++; if ({b_rdy0, b_rdy1} !== {~r1_tab[c], r1_tab[c]}) begin
        errors++; $display("FAIL starve_clear[%0d] got %b expected %b", c, {b_rdy0, b_rdy1}, {~r1_tab[c], r1_tab[c]});
      end
      @(posedge clk); #1;
    end
    b_v0 = 1'b0; b_v1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("starvation: counter clear sequence done");
  endtask

  task automatic test_flush();
    a_v0 = 1'b1; a_fun0 = F_ADD; a_sgn0 = 1'b0; a_opa0 = 32'd5; a_opb0 = 32'd7;
    #1;
    checks++; if (a_rdy0 !== 1'b1) begin
      errors++; $display("FAIL flush_pre_ready got %b expected 1", a_rdy0);
    end
    @(posedge clk); #1;
    a_v0 = 1'b0; a_flush = 1'b1;
    a_v1 = 1'b1; a_fun1 = F_SUB; a_sgn1 = 1'b0; a_opa1 = 32'd20; a_opb1 = 32'd5;
    #1;
    checks++; if ({a_rdy0, a_rdy1, a_busy} !== 3'b001) begin
      errors++; $display("FAIL flush_no_grant got rdy0=%b rdy1=%b busy=%b expected 0 0 1", a_rdy0, a_rdy1, a_busy);
    end
    @(posedge clk); #1;
    checks++; if ({a_rsp0, a_rsp1, a_busy} !== 3'b000) begin
      errors++; $display("FAIL flush_killed got rsp0=%b rsp1=%b busy=%b expected 0 0 0", a_rsp0, a_rsp1, a_busy);
    end
    a_flush = 1'b0;
    #1;
    checks++; if (a_rdy1 !== 1'b1) begin
      errors++; $display("FAIL flush_after_ready got %b expected 1", a_rdy1);
    end
    @(posedge clk); #1;
    a_v1 = 1'b0;
    @(posedge clk); #1;
    checks++; if ({a_rsp0, a_rsp1, a_rsp_z} !== {2'b01, 32'd15}) begin
      errors++; $display("FAIL flush_after_rsp got rsp0=%b rsp1=%b z=%0d expected 0 1 15", a_rsp0, a_rsp1, a_rsp_z);
    end
    $display("flush: killed op dropped, next op z=%0d", a_rsp_z);
  endtask

  task automatic test_reset_midstream();
    a_v0 = 1'b1; a_fun0 = F_ADD; a_opa0 = 32'd5; a_opb0 = 32'd7;
    a_v1 = 1'b1; a_fun1 = F_ADD; a_opa1 = 32'd1; a_opb1 = 32'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_v0 = 1'b0; a_v1 = 1'b0;
    checks++; if ({(a_rsp0 ^ a_rsp1), a_busy} !== 2'b11) begin
      errors++; $display("FAIL midreset_pending got rsp0=%b rsp1=%b busy=%b expected one rsp and busy", a_rsp0, a_rsp1, a_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({a_rsp0, a_rsp1, a_busy, a_rsp_z} !== 35'd0) begin
      errors++; $display("FAIL midreset_rsp got rsp0=%b rsp1=%b busy=%b z=%h expected all 0", a_rsp0, a_rsp1, a_busy, a_rsp_z);
    end
    checks++; if ({a_alu_a, a_alu_b, a_alu_fun, a_alu_sign} !== 71'd0) begin
      errors++; $display("FAIL midreset_alu got %h expected 0", {a_alu_a, a_alu_b, a_alu_fun, a_alu_sign});
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_v0 = 1'b1; a_v1 = 1'b1;
    #1;
    checks++; if ({a_rdy0, a_rdy1} !== 2'b10) begin
      errors++; $display("FAIL midreset_first_tie got %b expected 10", {a_rdy0, a_rdy1});
    end
    @(posedge clk); #1;
    a_v0 = 1'b0; a_v1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("reset_midstream: outputs cleared, first tie to port 0");
  endtask

  task automatic test_back_to_back_slt();
    a_v0 = 1'b1; a_fun0 = F_SLT; a_sgn0 = 1'b1; a_opa0 = 32'hFFFF_FFFF; a_opb0 = 32'd1;
    #1;
    checks++; if (a_rdy0 !== 1'b1) begin
      errors++; $display("FAIL slt_ready got %b expected 1", a_rdy0);
    end
    @(posedge clk); #1;
    checks++; if ({a_alu_fun, a_alu_sign} !== {F_SLT, 1'b1}) begin
      errors++; $display("FAIL slt_passthru got fun=%b sign=%b expected 110101 1", a_alu_fun, a_alu_sign);
    end
    a_sgn0 = 1'b0;
    @(posedge clk); #1;
    a_v0 = 1'b0;
    checks++; if ({a_rsp0, a_rsp_z, a_alu_sign} !== {1'b1, 32'd1, 1'b0}) begin
      errors++; $display("FAIL slt_signed got rsp0=%b z=%0d alu_sign=%b expected 1 1 0", a_rsp0, a_rsp_z, a_alu_sign);
    end
    $display("slt: signed -1<1 z=%0d", a_rsp_z);
    @(posedge clk); #1;
    checks++; if ({a_rsp0, a_rsp_z} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL slt_unsigned got rsp0=%b z=%0d expected 1 0", a_rsp0, a_rsp_z);
    end
    $display("slt: unsigned 0xFFFFFFFF<1 z=%0d", a_rsp_z);
    @(posedge clk); #1;
    checks++; if (a_busy !== 1'b0) begin
      errors++; $display("FAIL slt_idle_busy got %b expected 0", a_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_round_robin();
    test_starvation();
    test_flush();
    test_reset_midstream();
    test_back_to_back_slt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
